// File: rtl/master_cmd_queue.sv
// Command FIFO in front of the bus master: issues one command at a time, tracks M_BSY, returns read data.
// Optional build macro HOLD_BURST_EN drives M_HOLD across back-to-back commands; otherwise M_HOLD is 0.
module master_cmd_queue #(
    parameter int DEPTH       = 4,
    parameter int BSY_TIMEOUT = 16,
    parameter int CNT_W       = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             H_VALID,
    output logic             H_READY,
    input  logic [15:0]      H_ADDR,
    input  logic [7:0]       H_DIN,
    input  logic             H_RW,
    output logic [15:0]      M_ADDR,
    output logic [7:0]       M_DIN,
    output logic             M_RW,
    output logic             M_EXECUTE,
    output logic             M_HOLD,
    input  logic             M_BSY,
    input  logic             M_DVALID,
    input  logic [7:0]       M_DOUT,
    output logic             R_VALID,
    input  logic             R_READY,
    output logic [7:0]       R_DATA,
    output logic [15:0]      R_ADDR,
    output logic [CNT_W-1:0] Q_COUNT,
    output logic             Q_EMPTY,
    output logic             ERR_TIMEOUT,
    input  logic             ERR_CLR
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TMO_W = (BSY_TIMEOUT > 2) ? $clog2(BSY_TIMEOUT) : 1;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  din;
        logic        rw;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, EXEC, WAIT_BSY, WAIT_DONE} state_t;

    cmd_t             mem [DEPTH];
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [TMO_W-1:0] tmo_cnt;
    state_t           state;
    logic             full, push, pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign H_READY = !full;
    assign Q_EMPTY = (count == '0);
    assign Q_COUNT = count;
    assign head    = mem[rd_ptr];
    assign push    = H_VALID && !full;
    // Reads wait for the response slot; writes may pass a pending response but never reorder.
    assign pop     = (state == IDLE) && !Q_EMPTY && (head.rw || !R_VALID);

`ifdef HOLD_BURST_EN
    assign M_HOLD = (state != IDLE) && (count != '0);
`else
    assign M_HOLD = 1'b0;
`endif

    // NOTE: storage array has no reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= '{addr: H_ADDR, din: H_DIN, rw: H_RW};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: non-blocking assignments only, so later statements here override earlier ones on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            M_ADDR      <= '0;
            M_DIN       <= '0;
            M_RW        <= 1'b0;
            M_EXECUTE   <= 1'b0;
            R_VALID     <= 1'b0;
            R_DATA      <= '0;
            R_ADDR      <= '0;
            ERR_TIMEOUT <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            if (R_VALID && R_READY)
                R_VALID <= 1'b0;
            if (ERR_CLR)
                ERR_TIMEOUT <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        M_ADDR    <= head.addr;
                        M_DIN     <= head.din;
                        M_RW      <= head.rw;
                        M_EXECUTE <= 1'b1;
                        state     <= EXEC;
                        if (!head.rw)
                            R_DATA <= '0;
                    end
                end
                EXEC: begin
                    M_EXECUTE <= 1'b0;
                    tmo_cnt   <= '0;
                    state     <= WAIT_BSY;
                end
                WAIT_BSY: begin
                    if (M_BSY)
                        state <= WAIT_DONE;
                    else if (tmo_cnt == TMO_W'(BSY_TIMEOUT - 1)) begin
                        ERR_TIMEOUT <= 1'b1;
                        state       <= IDLE;
                    end else
                        tmo_cnt <= tmo_cnt + 1'b1;
                end
                WAIT_DONE: begin
                    if (M_DVALID && !M_RW)
                        R_DATA <= M_DOUT;
                    if (!M_BSY) begin
                        state <= IDLE;
                        if (!M_RW) begin
                            R_VALID <= 1'b1;
                            R_ADDR  <= M_ADDR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_master_cmd_queue.sv
// Directed bench for master_cmd_queue with a small bus-master responder model.
module tb_master_cmd_queue;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        H_VALID = 1'b0, H_RW = 1'b0, M_BSY, M_DVALID;
    logic        H_READY, M_RW, M_EXECUTE, M_HOLD, R_VALID, Q_EMPTY, ERR_TIMEOUT;
    logic        R_READY = 1'b0, ERR_CLR = 1'b0;
    logic [15:0] H_ADDR = '0, M_ADDR, R_ADDR;
    logic [7:0]  H_DIN = '0, M_DIN, M_DOUT, R_DATA;
    logic [2:0]  Q_COUNT;

    master_cmd_queue #(.DEPTH(4), .BSY_TIMEOUT(16), .CNT_W(3)) dut (
        .CLK(CLK), .RST(RST), .H_VALID(H_VALID), .H_READY(H_READY), .H_ADDR(H_ADDR),
        .H_DIN(H_DIN), .H_RW(H_RW), .M_ADDR(M_ADDR), .M_DIN(M_DIN), .M_RW(M_RW),
        .M_EXECUTE(M_EXECUTE), .M_HOLD(M_HOLD), .M_BSY(M_BSY), .M_DVALID(M_DVALID),
        .M_DOUT(M_DOUT), .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA),
        .R_ADDR(R_ADDR), .Q_COUNT(Q_COUNT), .Q_EMPTY(Q_EMPTY), .ERR_TIMEOUT(ERR_TIMEOUT),
        .ERR_CLR(ERR_CLR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Master model controls and observations.
    int          exec_cnt   = 0;
    int          exec_wide  = 0;
    logic [15:0] exec_addr  = '0;
    logic [7:0]  exec_din   = '0;
    logic        exec_rw    = 1'b0;
    logic        exec_hold [8];
    logic        stuck      = 1'b0;
    logic        dvalid_en  = 1'b1;
    logic        model_busy = 1'b0;
    logic [7:0]  rd_data    = '0;
    int          bsy_len    = 5;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Responder: M_BSY rises two cycles after M_EXECUTE, with one M_DVALID beat on reads.
    initial begin
        M_BSY = 1'b0;
        M_DVALID = 1'b0;
        M_DOUT = '0;
        forever begin
            @(negedge CLK);
            if (M_EXECUTE && !RST) begin
                exec_addr = M_ADDR;
                exec_din  = M_DIN;
                exec_rw   = M_RW;
                exec_hold[exec_cnt % 8] = M_HOLD;
                exec_cnt++;
                @(negedge CLK);
                if (M_EXECUTE)
                    exec_wide++;
                if (!stuck) begin
                    model_busy = 1'b1;
                    @(negedge CLK);
                    M_BSY = 1'b1;
                    for (int k = 0; k < bsy_len && !RST; k++) begin
                        if (k == 1 && dvalid_en && !exec_rw) begin
                            M_DVALID = 1'b1;
                            M_DOUT   = rd_data;
                        end else
                            M_DVALID = 1'b0;
                        @(negedge CLK);
                    end
                    M_DVALID   = 1'b0;
                    M_BSY      = 1'b0;
                    model_busy = 1'b0;
                end
            end
        end
    end

    task automatic push(input logic [15:0] a, input logic [7:0] d, input logic rw);
        H_ADDR  = a;
        H_DIN   = d;
        H_RW    = rw;
        H_VALID = 1'b1;
        @(negedge CLK);
        H_VALID = 1'b0;
    endtask

    task automatic wait_exec(input int n, input string tag);
        int i = 0;
        while (exec_cnt < n && i < 200) begin
            @(negedge CLK);
            i++;
        end
        check(tag, 32'(exec_cnt >= n), 32'd1);
    endtask

    task automatic wait_rvalid(input string tag);
        int i = 0;
        while (R_VALID !== 1'b1 && i < 100) begin
            @(negedge CLK);
            i++;
        end
        check(tag, 32'(R_VALID), 32'd1);
    endtask

    task automatic wait_quiet(input string tag);
        int i = 0;
        while ((model_busy || !Q_EMPTY) && i < 200) begin
            @(negedge CLK);
            i++;
        end
        check(tag, 32'(i < 200), 32'd1);
        repeat (3) @(negedge CLK);
    endtask

    task automatic consume();
        R_READY = 1'b1;
        @(negedge CLK);
        R_READY = 1'b0;
    endtask

    initial begin
        int base, lat, i;
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // Reset state
        check("rst_count", 32'(Q_COUNT), 32'd0);
        check("rst_empty", 32'(Q_EMPTY), 32'd1);
        check("rst_hready", 32'(H_READY), 32'd1);
        check("rst_exec", 32'(M_EXECUTE), 32'd0);
        check("rst_hold", 32'(M_HOLD), 32'd0);
        check("rst_maddr", 32'(M_ADDR), 32'd0);
        check("rst_mdin", 32'(M_DIN), 32'd0);
        check("rst_mrw", 32'(M_RW), 32'd0);
        check("rst_rvalid", 32'(R_VALID), 32'd0);
        check("rst_rdata", 32'(R_DATA), 32'd0);
        check("rst_raddr", 32'(R_ADDR), 32'd0);
        check("rst_err", 32'(ERR_TIMEOUT), 32'd0);

        // Single write
        push(16'h1234, 8'hA5, 1'b1);
        wait_exec(1, "wr_exec_seen");
        check("wr_addr", 32'(exec_addr), 32'h1234);
        check("wr_din", 32'(exec_din), 32'hA5);
        check("wr_rw", 32'(exec_rw), 32'd1);
        wait_quiet("wr_done");
        check("wr_no_resp", 32'(R_VALID), 32'd0);
        check("wr_addr_held", 32'(M_ADDR), 32'h1234);
        check("wr_exec_low", 32'(M_EXECUTE), 32'd0);

        // Single read
        rd_data = 8'h3C;
        push(16'h0010, 8'h00, 1'b0);
        wait_rvalid("rd_rvalid");
        check("rd_data", 32'(R_DATA), 32'h3C);
        check("rd_addr", 32'(R_ADDR), 32'h0010);
        consume();
        check("rd_consumed", 32'(R_VALID), 32'd0);

        // Read completing without M_DVALID returns zero data
        dvalid_en = 1'b0;
        rd_data   = 8'hFF;
        push(16'h0050, 8'h00, 1'b0);
        wait_rvalid("nodv_rvalid");
        check("nodv_data", 32'(R_DATA), 32'h00);
        check("nodv_addr", 32'(R_ADDR), 32'h0050);
        consume();
        dvalid_en = 1'b1;

        // Two reads then a write while the response is not consumed
        base = exec_cnt;
        rd_data = 8'h11;
        push(16'h0020, 8'h00, 1'b0);
        push(16'h0030, 8'h00, 1'b0);
        push(16'h0040, 8'h99, 1'b1);
        wait_exec(base + 1, "b2b_first_exec");
        wait_rvalid("b2b_first_rvalid");
        rd_data = 8'h22;
        repeat (20) @(negedge CLK);
        check("b2b_blocked_exec", 32'(exec_cnt), 32'(base + 1));
        check("b2b_blocked_count", 32'(Q_COUNT), 32'd2);
        check("b2b_first_data", 32'(R_DATA), 32'h11);
        check("b2b_first_addr", 32'(R_ADDR), 32'h0020);
        consume();
        wait_exec(base + 2, "b2b_second_exec");
        check("b2b_second_addr", 32'(exec_addr), 32'h0030);
        wait_rvalid("b2b_second_rvalid");
        wait_exec(base + 3, "b2b_write_exec");
        check("b2b_write_addr", 32'(exec_addr), 32'h0040);
        check("b2b_write_rw", 32'(exec_rw), 32'd1);
        wait_quiet("b2b_quiet");
        check("b2b_resp_kept", 32'(R_VALID), 32'd1);
        check("b2b_second_data", 32'(R_DATA), 32'h22);
        consume();

        // Full queue and M_BSY stuck low
        rd_data = 8'h5A;
        push(16'h0060, 8'h00, 1'b0);
        wait_rvalid("to_pending_rvalid");
        stuck = 1'b1;
        base = exec_cnt;
        check("to_ready_before", 32'(H_READY), 32'd1);
        for (int k = 0; k < 4; k++)
            push(16'h0100 + 16'(k), 8'h00, 1'b0);
        check("to_full_count", 32'(Q_COUNT), 32'd4);
        check("to_full_ready", 32'(H_READY), 32'd0);
        H_ADDR  = 16'h0104;
        H_VALID = 1'b1;
        @(negedge CLK);
        H_VALID = 1'b0;
        check("to_fifth_refused", 32'(Q_COUNT), 32'd4);
        consume();
        i = 0;
        while (M_EXECUTE !== 1'b1 && i < 10) begin
            @(negedge CLK);
            i++;
        end
        check("to_exec_seen", 32'(M_EXECUTE), 32'd1);
        lat = 0;
        while (ERR_TIMEOUT !== 1'b1 && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        check("to_latency", 32'(lat), 32'd17);
        check("to_count_after", 32'(Q_COUNT), 32'd3);
        check("to_no_resp", 32'(R_VALID), 32'd0);
        ERR_CLR = 1'b1;
        @(negedge CLK);
        check("to_err_cleared", 32'(ERR_TIMEOUT), 32'd0);
        wait_exec(base + 4, "to_drain_exec");
        i = 0;
        while (ERR_TIMEOUT !== 1'b1 && i < 30) begin
            @(negedge CLK);
            i++;
        end
        check("to_set_wins", 32'(ERR_TIMEOUT), 32'd1);
        @(negedge CLK);
        check("to_clear_after", 32'(ERR_TIMEOUT), 32'd0);
        ERR_CLR = 1'b0;
        check("to_drained", 32'(Q_EMPTY), 32'd1);
        check("to_drain_no_resp", 32'(R_VALID), 32'd0);
        stuck = 1'b0;

        // Reset during WAIT_DONE with three commands queued and a response pending
        rd_data = 8'h77;
        push(16'h0070, 8'h00, 1'b0);
        wait_rvalid("rs_pending_rvalid");
        bsy_len = 20;
        for (int k = 0; k < 4; k++)
            push(16'h0200 + 16'(k), 8'h10, 1'b1);
        repeat (3) @(negedge CLK);
        check("rs_pre_count", 32'(Q_COUNT), 32'd3);
        check("rs_pre_bsy", 32'(M_BSY), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        check("rs_count", 32'(Q_COUNT), 32'd0);
        check("rs_empty", 32'(Q_EMPTY), 32'd1);
        check("rs_rvalid", 32'(R_VALID), 32'd0);
        check("rs_rdata", 32'(R_DATA), 32'd0);
        check("rs_exec", 32'(M_EXECUTE), 32'd0);
        check("rs_maddr", 32'(M_ADDR), 32'd0);
        RST = 1'b0;
        base = exec_cnt;
        repeat (30) @(negedge CLK);
        check("rs_no_exec", 32'(exec_cnt), 32'(base));
        bsy_len = 5;

        // Three back-to-back writes: M_HOLD sampled at each M_EXECUTE
        base = exec_cnt;
        for (int k = 0; k < 3; k++)
            push(16'h0300 + 16'(k), 8'h40 + 8'(k), 1'b1);
        wait_exec(base + 3, "hold_exec");
        wait_quiet("hold_quiet");
`ifdef HOLD_BURST_EN
        check("hold_cmd1", 32'(exec_hold[base % 8]), 32'd1);
        check("hold_cmd2", 32'(exec_hold[(base + 1) % 8]), 32'd1);
`else
        check("hold_cmd1", 32'(exec_hold[base % 8]), 32'd0);
        check("hold_cmd2", 32'(exec_hold[(base + 1) % 8]), 32'd0);
`endif
        check("hold_cmd3", 32'(exec_hold[(base + 2) % 8]), 32'd0);
        check("hold_idle", 32'(M_HOLD), 32'd0);
        check("exec_one_cycle", 32'(exec_wide), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
